// File: rtl/kv_ledger_pkg.sv
// Shared opcodes, status codes and FSM encoding for the key/balance ledger.
package kv_ledger_pkg;

    localparam logic [2:0] OP_ISSUE    = 3'd1;
    localparam logic [2:0] OP_TRANSFER = 3'd2;
    localparam logic [2:0] OP_REFER    = 3'd3;
    localparam logic [2:0] OP_CREATE   = 3'd4;

    localparam logic [2:0] OK     = 3'd0;
    localparam logic [2:0] NOKEY  = 3'd1;
    localparam logic [2:0] EXISTS = 3'd2;
    localparam logic [2:0] FULL   = 3'd3;
    localparam logic [2:0] FUNDS  = 3'd4;
    localparam logic [2:0] OVF    = 3'd5;
    localparam logic [2:0] SAME   = 3'd6;
    localparam logic [2:0] BADOP  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/kv_ledger_if.sv
// Command/response bus between the command extractor and the ledger stage.
interface kv_ledger_if #(
    parameter int DEPTH = 8,
    parameter int KEY_W = 32,
    parameter int VAL_W = 32
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [2:0]               cmd_op;
    logic [KEY_W-1:0]         cmd_key_a;
    logic [KEY_W-1:0]         cmd_key_b;
    logic [VAL_W-1:0]         cmd_amount;
    logic                     rsp_valid;
    logic [2:0]               rsp_status;
    logic [VAL_W-1:0]         rsp_value;
    logic [$clog2(DEPTH):0]   entry_count;

    modport master (
        output cmd_valid, cmd_op, cmd_key_a, cmd_key_b, cmd_amount,
        input  cmd_ready, rsp_valid, rsp_status, rsp_value, entry_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_key_a, cmd_key_b, cmd_amount,
        output cmd_ready, rsp_valid, rsp_status, rsp_value, entry_count
    );
endinterface

// File: rtl/kv_table.sv
// Key/balance slot storage: one combinational read port, two write ports.
// Only the valid bits are reset; key/balance contents are don't-care when invalid.
module kv_table #(
    parameter int DEPTH = 8,
    parameter int KEY_W = 32,
    parameter int VAL_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic                     rd_vld_o,
    output logic [KEY_W-1:0]         rd_key_o,
    output logic [VAL_W-1:0]         rd_bal_o,
    input  logic                     wr0_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr0_idx_i,
    input  logic [KEY_W-1:0]         wr0_key_i,
    input  logic [VAL_W-1:0]         wr0_bal_i,
    input  logic                     wr1_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr1_idx_i,
    input  logic [KEY_W-1:0]         wr1_key_i,
    input  logic [VAL_W-1:0]         wr1_bal_i
);
    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][KEY_W-1:0] key_q;
    logic [DEPTH-1:0][VAL_W-1:0] bal_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            if (wr0_en_i) vld_q[wr0_idx_i] <= 1'b1;
            if (wr1_en_i) vld_q[wr1_idx_i] <= 1'b1;
        end
    end

    // The ledger never aims both ports at one slot; port 1 wins if it ever did.
    always_ff @(posedge clk_i) begin
        if (wr0_en_i) begin
            key_q[wr0_idx_i] <= wr0_key_i;
            bal_q[wr0_idx_i] <= wr0_bal_i;
        end
        if (wr1_en_i) begin
            key_q[wr1_idx_i] <= wr1_key_i;
            bal_q[wr1_idx_i] <= wr1_bal_i;
        end
    end

    assign rd_vld_o = vld_q[rd_idx_i];
    assign rd_key_o = key_q[rd_idx_i];
    assign rd_bal_o = bal_q[rd_idx_i];

endmodule

// File: rtl/kv_ledger.sv
// Ledger execution stage: linear scan of the slot table, then a single
// evaluate/write cycle, then a one-cycle response pulse.
module kv_ledger
    import kv_ledger_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int KEY_W = 32,
    parameter int VAL_W = 32
) (
    input  logic      clock,
    input  logic      reset,
    kv_ledger_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    state_t           state_q;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic [2:0]       rsp_status_q;
    logic [VAL_W-1:0] rsp_value_q;
    logic [CW-1:0]    count_q;

    logic [2:0]       op_q;
    logic [KEY_W-1:0] key_a_q, key_b_q;
    logic [VAL_W-1:0] amt_q;
    logic [IW-1:0]    idx_q;
    logic             hit_a_q, hit_b_q, free_q;
    logic [IW-1:0]    idx_a_q, idx_b_q, idx_free_q;
    logic [VAL_W-1:0] bal_a_q, bal_b_q;

    logic             rd_vld;
    logic [KEY_W-1:0] rd_key;
    logic [VAL_W-1:0] rd_bal;

    logic [2:0]       status_d;
    logic [VAL_W-1:0] value_d;
    logic             wr0_d, wr1_d, inc_d;
    logic [IW-1:0]    wr0_idx_d;
    logic [VAL_W-1:0] wr0_bal_d;
    logic [VAL_W:0]   sum_a, sum_b;
    logic [VAL_W-1:0] diff_a;

    assign sum_a  = {1'b0, bal_a_q} + {1'b0, amt_q};
    assign sum_b  = {1'b0, bal_b_q} + {1'b0, amt_q};
    assign diff_a = bal_a_q - amt_q;

    // Checks are ordered; the first failing one decides the status.
    always_comb begin
        status_d  = OK;
        value_d   = '0;
        wr0_d     = 1'b0;
        wr1_d     = 1'b0;
        inc_d     = 1'b0;
        wr0_idx_d = idx_a_q;
        wr0_bal_d = '0;
        case (op_q)
            OP_CREATE: begin
                if (hit_a_q)      status_d = EXISTS;
                else if (!free_q) status_d = FULL;
                else begin
                    wr0_d     = 1'b1;
                    inc_d     = 1'b1;
                    wr0_idx_d = idx_free_q;
                    wr0_bal_d = amt_q;
                    value_d   = amt_q;
                end
            end
            OP_ISSUE: begin
                if (!hit_a_q)         status_d = NOKEY;
                else if (sum_a[VAL_W]) status_d = OVF;
                else begin
                    wr0_d     = 1'b1;
                    wr0_bal_d = sum_a[VAL_W-1:0];
                    value_d   = sum_a[VAL_W-1:0];
                end
            end
            OP_TRANSFER: begin
                if (key_a_q == key_b_q)      status_d = SAME;
                else if (!hit_a_q || !hit_b_q) status_d = NOKEY;
                else if (bal_a_q < amt_q)    status_d = FUNDS;
                else if (sum_b[VAL_W])       status_d = OVF;
                else begin
                    wr0_d     = 1'b1;
                    wr1_d     = 1'b1;
                    wr0_bal_d = diff_a;
                    value_d   = diff_a;
                end
            end
            OP_REFER: begin
                if (!hit_a_q) status_d = NOKEY;
                else          value_d  = bal_a_q;
            end
            default: status_d = BADOP;
        endcase
    end

    kv_table #(.DEPTH(DEPTH), .KEY_W(KEY_W), .VAL_W(VAL_W)) u_table (
        .clk_i     (clock),
        .rst_i     (reset),
        .rd_idx_i  (idx_q),
        .rd_vld_o  (rd_vld),
        .rd_key_o  (rd_key),
        .rd_bal_o  (rd_bal),
        .wr0_en_i  (wr0_d && state_q == EXEC),
        .wr0_idx_i (wr0_idx_d),
        .wr0_key_i (key_a_q),
        .wr0_bal_i (wr0_bal_d),
        .wr1_en_i  (wr1_d && state_q == EXEC),
        .wr1_idx_i (idx_b_q),
        .wr1_key_i (key_b_q),
        .wr1_bal_i (sum_b[VAL_W-1:0])
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= '0;
            rsp_value_q  <= '0;
            count_q      <= '0;
            op_q         <= '0;
            key_a_q      <= '0;
            key_b_q      <= '0;
            amt_q        <= '0;
            idx_q        <= '0;
            hit_a_q      <= 1'b0;
            hit_b_q      <= 1'b0;
            free_q       <= 1'b0;
            idx_a_q      <= '0;
            idx_b_q      <= '0;
            idx_free_q   <= '0;
            bal_a_q      <= '0;
            bal_b_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        op_q        <= bus.cmd_op;
                        key_a_q     <= bus.cmd_key_a;
                        key_b_q     <= bus.cmd_key_b;
                        amt_q       <= bus.cmd_amount;
                        hit_a_q     <= 1'b0;
                        hit_b_q     <= 1'b0;
                        free_q      <= 1'b0;
                        idx_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (rd_vld && !hit_a_q && rd_key == key_a_q) begin
                        hit_a_q <= 1'b1;
                        idx_a_q <= idx_q;
                        bal_a_q <= rd_bal;
                    end
                    if (rd_vld && !hit_b_q && rd_key == key_b_q) begin
                        hit_b_q <= 1'b1;
                        idx_b_q <= idx_q;
                        bal_b_q <= rd_bal;
                    end
                    if (!rd_vld && !free_q) begin
                        free_q     <= 1'b1;
                        idx_free_q <= idx_q;
                    end
                    if (idx_q == LAST) state_q <= EXEC;
                    else               idx_q   <= idx_q + IW'(1);
                end
                EXEC: begin
                    rsp_status_q <= status_d;
                    rsp_value_q  <= value_d;
                    if (inc_d) count_q <= count_q + CW'(1);
                    state_q <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= 1'b1;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_status  = rsp_status_q;
    assign bus.rsp_value   = rsp_value_q;
    assign bus.entry_count = count_q;

endmodule

// File: tb/tb_kv_ledger.sv
// Directed vector bench for kv_ledger (DEPTH=8): table of commands with
// hand-computed responses plus handshake, full-table and mid-scan reset sequences.
module tb_kv_ledger;
    localparam int DEPTH = 8;
    localparam int LAT   = DEPTH + 2;
    localparam int NV    = 26;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] ka;
        logic [31:0] kb;
        logic [31:0] amt;
        logic [2:0]  st;
        logic [31:0] val;
        logic [3:0]  cnt;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs [NV];

    kv_ledger_if #(.DEPTH(DEPTH), .KEY_W(32), .VAL_W(32)) bus ();

    kv_ledger #(.DEPTH(DEPTH), .KEY_W(32), .VAL_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] ka, input logic [31:0] kb,
                                input logic [31:0] amt, input logic [2:0] st, input logic [31:0] val,
                                input logic [3:0] cnt);
        vec_t v;
        v.op = op; v.ka = ka; v.kb = kb; v.amt = amt; v.st = st; v.val = val; v.cnt = cnt;
        return v;
    endfunction

    // Issue one command and wait (bounded) for its response; inputs are
    // scrambled right after acceptance to prove they were latched.
    task automatic do_cmd(input logic [2:0] op, input logic [31:0] ka, input logic [31:0] kb,
                          input logic [31:0] amt, output logic [2:0] st, output logic [31:0] val,
                          output int lat);
        int w;
        lat = -1; st = 3'd0; val = 32'd0;
        @(negedge clock);
        w = 0;
        while (!bus.cmd_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        check("ready_before_cmd", {63'd0, bus.cmd_ready}, 64'd1);
        bus.cmd_op = op; bus.cmd_key_a = ka; bus.cmd_key_b = kb; bus.cmd_amount = amt;
        bus.cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'd6; bus.cmd_key_a = 32'hDEAD_BEEF; bus.cmd_key_b = 32'hDEAD_BEEF;
        bus.cmd_amount = 32'h1234_5678;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clock);
            #1;
            if (bus.rsp_valid) begin
                lat = n; st = bus.rsp_status; val = bus.rsp_value;
                break;
            end
        end
    endtask

    initial begin
        logic [2:0]  st;
        logic [31:0] val;
        int          lat;
        int          pulses, rdy_hits, badop_hits;

        vecs[0]  = mk(3'd3, 279,  0,   0,            3'd1, 0,            4'd0);
        vecs[1]  = mk(3'd4, 524,  0,   100,          3'd0, 100,          4'd1);
        vecs[2]  = mk(3'd4, 524,  0,   100,          3'd2, 0,            4'd1);
        vecs[3]  = mk(3'd4, 279,  0,   0,            3'd0, 0,            4'd2);
        vecs[4]  = mk(3'd1, 279,  0,   100,          3'd0, 100,          4'd2);
        vecs[5]  = mk(3'd1, 279,  0,   32'hFFFFFFFF, 3'd5, 0,            4'd2);
        vecs[6]  = mk(3'd3, 279,  0,   0,            3'd0, 100,          4'd2);
        vecs[7]  = mk(3'd4, 19,   0,   0,            3'd0, 0,            4'd3);
        vecs[8]  = mk(3'd2, 279,  19,  100,          3'd0, 0,            4'd3);
        vecs[9]  = mk(3'd3, 19,   0,   0,            3'd0, 100,          4'd3);
        vecs[10] = mk(3'd2, 279,  19,  1,            3'd4, 0,            4'd3);
        vecs[11] = mk(3'd2, 19,   19,  1,            3'd6, 0,            4'd3);
        vecs[12] = mk(3'd2, 279,  77,  0,            3'd1, 0,            4'd3);
        vecs[13] = mk(3'd2, 19,   524, 0,            3'd0, 100,          4'd3);
        vecs[14] = mk(3'd1, 524,  0,   32'hFFFFFF9B, 3'd0, 32'hFFFFFFFF, 4'd3);
        vecs[15] = mk(3'd2, 19,   524, 1,            3'd5, 0,            4'd3);
        vecs[16] = mk(3'd1, 77,   0,   5,            3'd1, 0,            4'd3);
        vecs[17] = mk(3'd4, 1001, 0,   10,           3'd0, 10,           4'd4);
        vecs[18] = mk(3'd4, 1002, 0,   20,           3'd0, 20,           4'd5);
        vecs[19] = mk(3'd4, 1003, 0,   30,           3'd0, 30,           4'd6);
        vecs[20] = mk(3'd4, 1004, 0,   40,           3'd0, 40,           4'd7);
        vecs[21] = mk(3'd4, 1005, 0,   50,           3'd0, 50,           4'd8);
        vecs[22] = mk(3'd4, 2000, 0,   1,            3'd3, 0,            4'd8);
        vecs[23] = mk(3'd3, 524,  0,   0,            3'd0, 32'hFFFFFFFF, 4'd8);
        vecs[24] = mk(3'd1, 1005, 0,   1,            3'd0, 51,           4'd8);
        vecs[25] = mk(3'd0, 1001, 0,   1,            3'd7, 0,            4'd8);

        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0;
        bus.cmd_key_a = 32'd0; bus.cmd_key_b = 32'd0; bus.cmd_amount = 32'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst cmd_ready",   {63'd0, bus.cmd_ready}, 64'd1);
        check("rst rsp_valid",   {63'd0, bus.rsp_valid}, 64'd0);
        check("rst rsp_status",  {61'd0, bus.rsp_status}, 64'd0);
        check("rst rsp_value",   {32'd0, bus.rsp_value}, 64'd0);
        check("rst entry_count", {60'd0, bus.entry_count}, 64'd0);

        for (int i = 0; i < NV; i++) begin
            do_cmd(vecs[i].op, vecs[i].ka, vecs[i].kb, vecs[i].amt, st, val, lat);
            check($sformatf("v%0d latency", i), 64'(lat), 64'(LAT));
            check($sformatf("v%0d status", i),  {61'd0, st}, {61'd0, vecs[i].st});
            check($sformatf("v%0d value", i),   {32'd0, val}, {32'd0, vecs[i].val});
            check($sformatf("v%0d count", i),   {60'd0, bus.entry_count}, {60'd0, vecs[i].cnt});
            @(posedge clock);
            #1;
            check($sformatf("v%0d pulse_width", i), {63'd0, bus.rsp_valid}, 64'd0);
        end

        // cmd_valid held high: accepts only at edges 0, 11, 22.
        pulses = 0; rdy_hits = 0; badop_hits = 0;
        @(negedge clock);
        bus.cmd_op = 3'd6; bus.cmd_key_a = 32'd1001; bus.cmd_amount = 32'd1;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            @(posedge clock);
            #1;
            if (bus.rsp_valid) begin
                pulses++;
                if (bus.rsp_status == 3'd7) badop_hits++;
            end
            if (bus.cmd_ready) rdy_hits++;
        end
        bus.cmd_valid = 1'b0;
        check("hold pulses",     64'(pulses), 64'd3);
        check("hold ready_hits", 64'(rdy_hits), 64'd3);
        check("hold badop",      64'(badop_hits), 64'd3);
        check("hold count",      {60'd0, bus.entry_count}, 64'd8);

        // Reset in the middle of a create's scan aborts it.
        @(negedge clock);
        bus.cmd_op = 3'd4; bus.cmd_key_a = 32'd524; bus.cmd_amount = 32'd7;
        bus.cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("midscan ready_low", {63'd0, bus.cmd_ready}, 64'd0);
        #1 reset = 1'b1;
        #2;
        check("midscan rst count", {60'd0, bus.entry_count}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            if (bus.rsp_valid) pulses++;
        end
        check("midscan no_rsp", 64'(pulses), 64'd0);
        check("midscan count",  {60'd0, bus.entry_count}, 64'd0);
        check("midscan ready",  {63'd0, bus.cmd_ready}, 64'd1);

        do_cmd(3'd4, 524, 0, 7, st, val, lat);
        check("post create status", {61'd0, st}, 64'd0);
        check("post create value",  {32'd0, val}, 64'd7);
        check("post create count",  {60'd0, bus.entry_count}, 64'd1);
        check("post create lat",    64'(lat), 64'(LAT));
        do_cmd(3'd3, 524, 0, 0, st, val, lat);
        check("post refer value",   {32'd0, val}, 64'd7);
        do_cmd(3'd4, 19, 0, 3, st, val, lat);
        check("post create2 status", {61'd0, st}, 64'd0);
        check("post create2 count",  {60'd0, bus.entry_count}, 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kv_ledger.md
Name: kv_ledger

Overview:
- Execution stage directly downstream of the command extractor.
- Consumes one decoded command at a time (opcode, two 32-bit keys, 32-bit amount) and applies it to a small on-chip key/balance table.
- Supported commands: issue, transfer, refer, create.
- Returns one status/value response per command. That response is the authoritative updated_value for the design.

Parameters:
- DEPTH, 8, number of table slots (power of two, 2..64).
- KEY_W, 32, key width in bits.
- VAL_W, 32, balance/amount width in bits.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  extractor presents a complete command.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_op  in  3  opcode: 1 issue, 2 transfer, 3 refer, 4 create.
- cmd_key_a  in  KEY_W  primary key (source for transfer).
- cmd_key_b  in  KEY_W  destination key (transfer only; ignored otherwise).
- cmd_amount  in  VAL_W  amount/initial value (ignored for refer).
- rsp_valid  out  1  one-cycle pulse: response fields are valid.
- rsp_status  out  3  result code.
- rsp_value  out  VAL_W  balance of key_a after the command (0 on error).
- entry_count  out  $clog2(DEPTH)+1  number of occupied slots.

Behaviour:
- Reset (async, active-high):
  - All slot valid bits cleared; FSM to IDLE.
  - cmd_ready=1 once reset deasserts; rsp_valid=0, rsp_status=0, rsp_value=0, entry_count=0.
  - Reset mid-command aborts it: no table write, no response.
- Handshake:
  - A command is accepted on a rising edge with cmd_valid & cmd_ready.
  - Inputs are latched at acceptance; later input changes are ignored.
  - cmd_ready is low from the accepting edge until the FSM is back in IDLE.
  - There is no rsp_ready; the response is a single pulse that the consumer must capture.
- FSM:
  - IDLE: on accept, latch the command, clear hit/free flags, index=0, go to SCAN.
  - SCAN: one slot per cycle, index 0..DEPTH-1.
    - Record hit_a/idx_a and hit_b/idx_b. On duplicate keys (impossible by construction), the first match wins.
    - Record the lowest-index free slot.
    - After index DEPTH-1, go to EXEC.
  - EXEC: evaluate the command, perform at most two slot writes, register the response, go to RESP.
  - RESP: rsp_valid=1 for exactly this cycle; next state IDLE with cmd_ready=1.
- Latency:
  - rsp_valid rises DEPTH+2 edges after the accepting edge.
  - Throughput: one command per DEPTH+3 cycles.
- Command rules (checks in the order listed; the first failing check sets the status and the table is unchanged):
  - create:
    - key_a present -> EXISTS.
    - No free slot -> FULL.
    - Otherwise write {key_a, amount} into the lowest free slot; entry_count+1; value=amount.
  - issue:
    - key_a absent -> NOKEY.
    - bal_a+amount carries out of VAL_W -> OVF.
    - Otherwise bal_a += amount.
  - transfer:
    - key_a == key_b -> SAME.
    - Either key absent -> NOKEY.
    - bal_a < amount -> FUNDS.
    - bal_b+amount overflows -> OVF.
    - Otherwise bal_a -= amount and bal_b += amount, both in the same EXEC edge; value=new bal_a.
  - refer:
    - key_a absent -> NOKEY.
    - Otherwise value=bal_a; no write.
  - Any other opcode -> BADOP.
- Arithmetic: unsigned, VAL_W bits. The overflow check uses a VAL_W+1 sum.
- Boundaries:
  - amount=0 is legal for every command (a transfer of 0 succeeds).
  - A full table rejects create but serves all other commands.
  - Entries are never deleted.

Decomposition:
- Package kv_ledger_pkg holds:
  - opcode constants OP_ISSUE=1, OP_TRANSFER=2, OP_REFER=3, OP_CREATE=4;
  - status constants OK=0, NOKEY=1, EXISTS=2, FULL=3, FUNDS=4, OVF=5, SAME=6, BADOP=7;
  - FSM state encoding IDLE/SCAN/EXEC/RESP.
- One sub-module, kv_table:
  - DEPTH-entry storage of key, balance and valid bit;
  - one combinational read port addressed by the scan index;
  - two synchronous write ports;
  - async clear of the valid bits.
  - The FSM and checks stay in kv_ledger.

Test Plan:
- Reset, then refer key 279 -> NOKEY, value 0, entry_count 0. rsp_valid must rise exactly 10 edges (DEPTH=8) after the accepting edge.
- create 524 amt 100 -> OK, value 100, count 1. Repeat the same create -> EXISTS, count stays 1.
- create 279 amt 0; issue 279 amt 100 -> OK, value 100. issue 279 amt 0xFFFFFFFF -> OVF, refer 279 -> 100.
- create 19 amt 0; transfer 279->19 amt 100 -> OK, value 0, refer 19 -> 100.
  - Then transfer 279->19 amt 1 -> FUNDS.
  - Then transfer 19->19 amt 1 -> SAME.
  - Then transfer 279->77 amt 0 -> NOKEY.
- Fill all 8 slots, then a ninth create -> FULL, count 8. Opcode 6 -> BADOP. Hold cmd_valid high throughout and confirm no command is accepted while cmd_ready is low.
- Assert reset during SCAN of a create -> no rsp_valid, count 0. After release, the same create -> OK in slot 0.
